// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD arithmetic blocks.
package bcd_pkg;

    localparam int unsigned DigitW = 4;

    localparam logic ModeAdd = 1'b0;
    localparam logic ModeSub = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/bcd_digit_cell.sv
// Single-digit BCD add/subtract cell; subtraction adds the nine's complement of b.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [DigitW-1:0] a,
    input  logic [DigitW-1:0] b,
    input  logic              cin,
    input  logic              sub,
    output logic [DigitW-1:0] digit,
    output logic              cout
);

    logic [DigitW-1:0] b_adj;
    logic [DigitW:0]   s;
    logic [DigitW:0]   s_fix;

    always_comb begin
        b_adj = sub ? (4'd9 - b) : b;
        s     = {1'b0, a} + {1'b0, b_adj} + {4'b0000, cin};
        s_fix = s + 5'd6;
        if (s > 5'd9) begin
            digit = s_fix[DigitW-1:0];
            cout  = 1'b1;
        end else begin
            digit = s[DigitW-1:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first,
// with the result held behind a valid/ready handshake.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int unsigned NDIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mode,
    input  logic                      c_in,
    input  logic [DigitW*NDIGITS-1:0] a,
    input  logic [DigitW*NDIGITS-1:0] b,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DigitW*NDIGITS-1:0] sum,
    output logic                      c_out,
    output logic                      err
);

    localparam int unsigned W    = DigitW * NDIGITS;
    localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIGITS - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            mode_q, mode_d, carry_q, carry_d, err_q, err_d;
    logic            launch, any_bad;
    logic [DigitW-1:0] cell_digit;
    logic            cell_cout;

    // Operands shift right each digit so the cell always sees the low nibble.
    bcd_digit_cell u_cell (
        .a     (a_q[DigitW-1:0]),
        .b     (b_q[DigitW-1:0]),
        .cin   (carry_q),
        .sub   (mode_q),
        .digit (cell_digit),
        .cout  (cell_cout)
    );

    assign launch = start && ((state_q == StIdle) || ((state_q == StDone) && out_ready));

    always_comb begin
        any_bad = 1'b0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if ((a[i*DigitW +: DigitW] > 4'd9) || (b[i*DigitW +: DigitW] > 4'd9)) begin
                any_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        err_d   = err_q;

        unique case (state_q)
            StRun: begin
                a_d     = a_q >> DigitW;
                b_d     = b_q >> DigitW;
                carry_d = cell_cout;
                sum_d[int'(idx_q)*DigitW +: DigitW] = cell_digit;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    idx_d   = '0;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Launch overrides: covers both IDLE start and the back-to-back DONE handshake.
        if (launch) begin
            state_d = StRun;
            idx_d   = '0;
            a_d     = a;
            b_d     = b;
            mode_d  = mode;
            carry_d = (mode == ModeSub) ? ~c_in : c_in;
            err_d   = any_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            mode_q  <= ModeAdd;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign c_out     = carry_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial: decimal reference model, random and directed traffic.
module tb_bcd_addsub_serial;

    localparam int N    = 4;
    localparam int W    = 4 * N;
    localparam int POW  = 10000;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         e;
    } exp_t;

    logic         clk, rst_n, start, mode, c_in, out_ready;
    logic [W-1:0] a, b, sum;
    logic         busy, out_valid, c_out, err;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    bcd_addsub_serial #(.NDIGITS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .c_in      (c_in),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    // Decimal arithmetic when all digits are legal; nibble rule only for illegal inputs.
    function automatic exp_t model(input logic m, input logic ci, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t r;
        int xv = 0, yv = 0, t, c, xd, yd;
        r.e = 1'b0;
        for (int i = 0; i < N; i++)
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) r.e = 1'b1;
        r.sum = '0;
        if (!r.e) begin
            for (int i = N - 1; i >= 0; i--) begin
                xv = xv * 10 + int'(x[4*i +: 4]);
                yv = yv * 10 + int'(y[4*i +: 4]);
            end
            if (m) begin
                t = xv - yv - int'(ci);
                r.co = (t >= 0);
                if (t < 0) t += POW;
            end else begin
                t = xv + yv + int'(ci);
                r.co = (t >= POW);
                t = t % POW;
            end
            for (int i = 0; i < N; i++) begin
                r.sum[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end else begin
            c = m ? int'(!ci) : int'(ci);
            for (int i = 0; i < N; i++) begin
                xd = int'(x[4*i +: 4]);
                yd = m ? ((9 - int'(y[4*i +: 4])) & 15) : int'(y[4*i +: 4]);
                t  = xd + yd + c;
                if (t > 9) begin t = (t + 6) & 15; c = 1; end
                else c = 0;
                r.sum[4*i +: 4] = 4'(t);
            end
            r.co = (c != 0);
        end
        return r;
    endfunction

    // Monitor: every accepted result is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected result", 32'd1, 32'd0);
            else begin
                mon_e = sb.pop_front();
                chk("sum", 32'(sum), 32'(mon_e.sum));
                chk("c_out", 32'(c_out), 32'(mon_e.co));
                chk("err", 32'(err), 32'(mon_e.e));
            end
        end
    end

    task automatic launch(input logic m, input logic ci, input logic [W-1:0] x,
                          input logic [W-1:0] y);
        mode = m; c_in = ci; a = x; b = y; start = 1'b1;
        sb.push_back(model(m, ci, x, y));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) chk("valid timeout", 32'd0, 32'd1);
    endtask

    task automatic accept(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle after accept", 32'(out_valid), 32'd0);
    endtask

    task automatic txn(input logic m, input logic ci, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int hold);
        int cyc;
        launch(m, ci, x, y);
        chk("busy after launch", 32'(busy), 32'd1);
        wait_valid(cyc);
        chk("latency", 32'(cyc), 32'(N));
        accept(hold);
    endtask

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++)
            v[4*i +: 4] = (allow_bad && ($urandom_range(0, 7) == 0)) ? 4'($urandom_range(10, 15))
                                                                      : 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        int cyc;
        exp_t es;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; c_in = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset c_out", 32'(c_out), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 1'b0, 16'h1234, 16'h8766, 0);
        txn(1'b1, 1'b0, 16'h0500, 16'h0123, 1);
        txn(1'b1, 1'b1, 16'h0500, 16'h0123, 0);
        txn(1'b1, 1'b0, 16'h0123, 16'h0500, 2);

        // Illegal nibble, result held while the consumer stalls.
        launch(1'b0, 1'b0, 16'h00A0, 16'h0001);
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            chk("hold valid", 32'(out_valid), 32'd1);
            chk("hold sum", 32'(sum), 32'h0101);
            chk("hold c_out", 32'(c_out), 32'd0);
            chk("hold err", 32'(err), 32'd1);
            @(posedge clk); #1;
        end
        accept(0);

        // Back-to-back relaunch on the handshake edge, plus ignored starts in RUN.
        launch(1'b0, 1'b0, 16'h1234, 16'h1111);
        wait_valid(cyc);
        mode = 1'b0; c_in = 1'b0; a = 16'h9999; b = 16'h0001;
        start = 1'b1; out_ready = 1'b1;
        sb.push_back(model(1'b0, 1'b0, 16'h9999, 16'h0001));
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b0;
        chk("b2b busy", 32'(busy), 32'd1);
        chk("b2b valid low", 32'(out_valid), 32'd0);
        a = 16'h5555; b = 16'h4444; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(cyc);
        chk("b2b latency", 32'(cyc), 32'(N - 1));
        accept(1);

        // Asynchronous reset in the middle of RUN.
        launch(1'b0, 1'b1, 16'h4321, 16'h5678);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort valid", 32'(out_valid), 32'd0);
        chk("abort sum", 32'(sum), 32'd0);
        chk("abort c_out", 32'(c_out), 32'd0);
        chk("abort err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 1'b1, 16'h4321, 16'h5678, 0);

        for (int i = 0; i < 40; i++)
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_bcd(1'b1),
                rand_bcd(1'b1), int'($urandom_range(0, 3)));

        es = model(1'b1, 1'b0, 16'h0000, 16'h0001);
        chk("model borrow sanity", 32'(es.sum), 32'h9999);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
